// File: rtl/hub75_bcm_scheduler_if.sv
// -----------------------------------------------------------------------------
// hub75_bcm_scheduler_if
//   Bundles the framebuffer read port and the HUB75 panel pins driven by
//   hub75_bcm_scheduler.
//
//   master : the scheduler. It drives the read strobe and address, and all
//            panel pins. It samples fb_data.
//   slave  : the framebuffer and panel side. It drives fb_data.
//
//   Signals:
//     fb_rd       read strobe; data is returned one clk later on fb_data
//     fb_row      read address, row
//     fb_col      read address, column
//     fb_plane    read address, bitplane
//     fb_data     {R1,G1,B1,R0,G0,B0}
//     sclk        panel shift clock
//     latch       panel LAT
//     oe_n        panel OE, active-low
//     addr        panel row address
//     rgb0        {R0,G0,B0}
//     rgb1        {R1,G1,B1}
//     frame_start one-cycle pulse on the first shift cycle of row 0 / plane 0
// -----------------------------------------------------------------------------
interface hub75_bcm_scheduler_if #(
  parameter int COLS   = 64,
  parameter int ROWS   = 16,
  parameter int PLANES = 4
);
  localparam int ROW_W   = (ROWS   > 1) ? $clog2(ROWS)   : 1;
  localparam int COL_W   = (COLS   > 1) ? $clog2(COLS)   : 1;
  localparam int PLANE_W = (PLANES > 1) ? $clog2(PLANES) : 1;

  logic               fb_rd;
  logic [ROW_W-1:0]   fb_row;
  logic [COL_W-1:0]   fb_col;
  logic [PLANE_W-1:0] fb_plane;
  logic [5:0]         fb_data;
  logic               sclk;
  logic               latch;
  logic               oe_n;
  logic [ROW_W-1:0]   addr;
  logic [2:0]         rgb0;
  logic [2:0]         rgb1;
  logic               frame_start;

  modport master (
    output fb_rd, fb_row, fb_col, fb_plane,
    input  fb_data,
    output sclk, latch, oe_n, addr, rgb0, rgb1, frame_start
  );

  modport slave (
    input  fb_rd, fb_row, fb_col, fb_plane,
    output fb_data,
    input  sclk, latch, oe_n, addr, rgb0, rgb1, frame_start
  );
endinterface

// File: rtl/hub75_bcm_scheduler.sv
// -----------------------------------------------------------------------------
// hub75_bcm_scheduler
//   Drives a HUB75 panel with binary-code modulation. For every row and
//   bitplane the block does four things in order:
//     1. It reads the row one column at a time from the framebuffer and
//        shifts the pixels into the panel.
//     2. It latches the shifted data.
//     3. It enables the LEDs for BASE_OE << plane cycles.
//     4. It blanks for one cycle.
//   Plane 0 is the LSB.
//
//   Ports:
//     clk  system clock; all logic runs on the rising edge
//     rst  synchronous reset, active-low
//     en   scan enable; sampled only at frame boundaries, so a frame that
//          has started always runs to completion
//     bus  master side of hub75_bcm_scheduler_if (framebuffer read port
//          and panel pins)
//
//   Every output is registered.
//
//   Timing of one SHIFT phase, with t = 0 .. 2*COLS:
//     even t < 2*COLS : issues the read for column t/2
//     odd t           : captures the returned pixel into rgb0/rgb1
//     even t >= 2     : sclk is high, so column k rises at t = 2k+2
//
//   Period of one plane: 2*COLS + 3 + (BASE_OE << plane) cycles.
// -----------------------------------------------------------------------------
module hub75_bcm_scheduler #(
  parameter int COLS    = 64,
  parameter int ROWS    = 16,
  parameter int PLANES  = 4,
  parameter int BASE_OE = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  hub75_bcm_scheduler_if.master   bus
);

  localparam int ROW_W   = (ROWS   > 1) ? $clog2(ROWS)   : 1;
  localparam int COL_W   = (COLS   > 1) ? $clog2(COLS)   : 1;
  localparam int PLANE_W = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int T_W     = $clog2(2 * COLS + 1);
  localparam int DCNT_W  = $clog2(BASE_OE << (PLANES - 1)) + 1;

  localparam logic [T_W-1:0]     T_LAST     = T_W'(2 * COLS);
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROWS - 1);
  localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(PLANES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    LATCH,
    DISPLAY,
    BLANK
  } state_t;

  state_t             state;
  logic [T_W-1:0]     t;
  logic [T_W-1:0]     t_nxt;
  logic [DCNT_W-1:0]  dcnt;
  logic [ROW_W-1:0]   row;
  logic [PLANE_W-1:0] plane;

  logic               fb_rd_q;
  logic [COL_W-1:0]   fb_col_q;
  logic               sclk_q;
  logic               latch_q;
  logic               oe_n_q;
  logic               frame_start_q;
  logic [ROW_W-1:0]   addr_q;
  logic [2:0]         rgb0_q;
  logic [2:0]         rgb1_q;

  // The counter is loaded with the length minus one. DISPLAY then ends
  // on the cycle where the counter reaches zero.
  function automatic logic [DCNT_W-1:0] display_last(input logic [PLANE_W-1:0] p);
    logic [DCNT_W-1:0] base;
    base = DCNT_W'(BASE_OE);
    return (base << p) - DCNT_W'(1);
  endfunction

  assign t_nxt = t + T_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      t             <= '0;
      dcnt          <= '0;
      row           <= '0;
      plane         <= '0;
      fb_rd_q       <= 1'b0;
      fb_col_q      <= '0;
      sclk_q        <= 1'b0;
      latch_q       <= 1'b0;
      oe_n_q        <= 1'b1;
      frame_start_q <= 1'b0;
      addr_q        <= '0;
      rgb0_q        <= '0;
      rgb1_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          oe_n_q  <= 1'b1;
          sclk_q  <= 1'b0;
          latch_q <= 1'b0;
          if (en) begin
            state         <= SHIFT;
            row           <= '0;
            plane         <= '0;
            t             <= '0;
            fb_rd_q       <= 1'b1;
            fb_col_q      <= '0;
            frame_start_q <= 1'b1;
          end
        end

        SHIFT: begin
          frame_start_q <= 1'b0;
          // The read issued on the previous even cycle has returned.
          if (t[0]) {rgb1_q, rgb0_q} <= bus.fb_data;
          if (t == T_LAST) begin
            state   <= LATCH;
            latch_q <= 1'b1;
            addr_q  <= row;
            sclk_q  <= 1'b0;
            fb_rd_q <= 1'b0;
          end else begin
            t        <= t_nxt;
            // t_nxt is at least 1, so an even t_nxt is already >= 2.
            // The read at t_nxt == T_LAST would be for a column past the
            // end of the line, so it is suppressed.
            fb_rd_q  <= !t_nxt[0] && (t_nxt != T_LAST);
            fb_col_q <= COL_W'(t_nxt >> 1);
            sclk_q   <= !t_nxt[0];
          end
        end

        LATCH: begin
          latch_q <= 1'b0;
          oe_n_q  <= 1'b0;
          dcnt    <= display_last(plane);
          state   <= DISPLAY;
        end

        DISPLAY: begin
          if (dcnt == '0) begin
            oe_n_q <= 1'b1;
            state  <= BLANK;
          end else begin
            dcnt <= dcnt - DCNT_W'(1);
          end
        end

        BLANK: begin
          // Start the next shift by default. The frame boundary with en
          // low overrides this and returns to IDLE instead.
          state    <= SHIFT;
          t        <= '0;
          fb_rd_q  <= 1'b1;
          fb_col_q <= '0;
          if (plane == PLANE_LAST) begin
            plane <= '0;
            if (row == ROW_LAST) begin
              row <= '0;
              if (en) begin
                frame_start_q <= 1'b1;
              end else begin
                state   <= IDLE;
                fb_rd_q <= 1'b0;
              end
            end else begin
              row <= row + ROW_W'(1);
            end
          end else begin
            plane <= plane + PLANE_W'(1);
          end
        end

        default: begin
          state   <= IDLE;
          oe_n_q  <= 1'b1;
          sclk_q  <= 1'b0;
          latch_q <= 1'b0;
          fb_rd_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fb_rd       = fb_rd_q;
  assign bus.fb_row      = row;
  assign bus.fb_col      = fb_col_q;
  assign bus.fb_plane    = plane;
  assign bus.sclk        = sclk_q;
  assign bus.latch       = latch_q;
  assign bus.oe_n        = oe_n_q;
  assign bus.addr        = addr_q;
  assign bus.rgb0        = rgb0_q;
  assign bus.rgb1        = rgb1_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_hub75_bcm_scheduler.sv
module tb_hub75_bcm_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic en2 = 1'b0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hub75_bcm_scheduler_if #(.COLS(64), .ROWS(16), .PLANES(4)) bus ();
  hub75_bcm_scheduler #(.COLS(64), .ROWS(16), .PLANES(4), .BASE_OE(8)) dut (
    .clk(clk), .rst(rst), .en(en), .bus(bus)
  );

  hub75_bcm_scheduler_if #(.COLS(4), .ROWS(2), .PLANES(2)) bus2 ();
  hub75_bcm_scheduler #(.COLS(4), .ROWS(2), .PLANES(2), .BASE_OE(1)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .bus(bus2)
  );

  // Framebuffer model with one-cycle read latency. Column c returns
  // {c[2:0], ~c[2:0]}, so column 5 returns {3'b101, 3'b010}.
  always @(posedge clk) begin
    if (!rst) bus.fb_data <= 6'd0;
    else if (bus.fb_rd) bus.fb_data <= {bus.fb_col[2:0], ~bus.fb_col[2:0]};
  end
  assign bus2.fb_data = 6'd0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    en  = 1'b0;
    tick();
    tick();
    tests++; if (bus.oe_n !== 1'b1) begin fails++; $display("FAIL reset_oe_n got=%b want=1", bus.oe_n); end
    tests++; if (bus.sclk !== 1'b0) begin fails++; $display("FAIL reset_sclk got=%b want=0", bus.sclk); end
    tests++; if (bus.latch !== 1'b0) begin fails++; $display("FAIL reset_latch got=%b want=0", bus.latch); end
    tests++; if (bus.fb_rd !== 1'b0) begin fails++; $display("FAIL reset_fb_rd got=%b want=0", bus.fb_rd); end
    tests++; if (bus.frame_start !== 1'b0) begin fails++; $display("FAIL reset_frame_start got=%b want=0", bus.frame_start); end
    tests++; if (bus.addr !== 4'd0) begin fails++; $display("FAIL reset_addr got=%0d want=0", bus.addr); end
    tests++; if (bus.rgb0 !== 3'd0 || bus.rgb1 !== 3'd0) begin fails++; $display("FAIL reset_rgb got=%b/%b want=000/000", bus.rgb1, bus.rgb0); end
    tests++; if (bus.fb_row !== 4'd0 || bus.fb_plane !== 2'd0) begin fails++; $display("FAIL reset_row_plane got=%0d/%0d want=0/0", bus.fb_row, bus.fb_plane); end
    rst = 1'b1;
    tick();
    tick();
    tests++; if (bus.oe_n !== 1'b1 || bus.fb_rd !== 1'b0 || bus.frame_start !== 1'b0) begin fails++; $display("FAIL idle_hold got oe_n=%b fb_rd=%b fs=%b want 1/0/0", bus.oe_n, bus.fb_rd, bus.frame_start); end
    en = 1'b1;
    tick();
    tests++; if (bus.frame_start !== 1'b1) begin fails++; $display("FAIL start_frame_start got=%b want=1", bus.frame_start); end
    tests++; if (bus.fb_rd !== 1'b1 || bus.fb_col !== 6'd0) begin fails++; $display("FAIL start_first_read got rd=%b col=%0d want 1/0", bus.fb_rd, bus.fb_col); end
  endtask

  // Entered at t=0 of row 0 / plane 0. Leaves on the LATCH cycle.
  task automatic test_shift_timing();
    int rises;
    rises = 0;
    for (int t = 0; t <= 128; t++) begin
      bit exp_rd;
      bit exp_sclk;
      exp_rd   = (t % 2 == 0) && (t < 128);
      exp_sclk = (t % 2 == 0) && (t >= 2);
      tests++; if (bus.fb_rd !== exp_rd) begin fails++; $display("FAIL shift_fb_rd t=%0d got=%b want=%b", t, bus.fb_rd, exp_rd); end
      if (exp_rd) begin
        tests++; if (bus.fb_col !== 6'(t / 2)) begin fails++; $display("FAIL shift_fb_col t=%0d got=%0d want=%0d", t, bus.fb_col, t / 2); end
      end
      tests++; if (bus.sclk !== exp_sclk) begin fails++; $display("FAIL shift_sclk t=%0d got=%b want=%b", t, bus.sclk, exp_sclk); end
      tests++; if (bus.oe_n !== 1'b1 || bus.latch !== 1'b0) begin fails++; $display("FAIL shift_oe_latch t=%0d got oe_n=%b latch=%b want 1/0", t, bus.oe_n, bus.latch); end
      if (bus.sclk === 1'b1) begin
        rises++;
        if (rises == 6) begin
          tests++; if (bus.rgb1 !== 3'b101 || bus.rgb0 !== 3'b010) begin fails++; $display("FAIL shift_col5_rgb got=%b/%b want=101/010", bus.rgb1, bus.rgb0); end
        end
      end
      if (t < 128) tick();
    end
    tick();
    tests++; if (bus.latch !== 1'b1 || bus.sclk !== 1'b0 || bus.oe_n !== 1'b1) begin fails++; $display("FAIL shift_to_latch got latch=%b sclk=%b oe_n=%b want 1/0/1", bus.latch, bus.sclk, bus.oe_n); end
    tests++; if (rises != 64) begin fails++; $display("FAIL shift_rise_count got=%0d want=64", rises); end
    tests++; if (bus.addr !== 4'd0) begin fails++; $display("FAIL shift_latch_addr got=%0d want=0", bus.addr); end
  endtask

  // Entered on the LATCH cycle of row 0 / plane 0. Leaves at t=0 of row 1.
  task automatic test_bcm_weights();
    for (int p = 0; p < 4; p++) begin
      int run;
      run = 0;
      tests++; if (bus.latch !== 1'b1 || bus.oe_n !== 1'b1) begin fails++; $display("FAIL bcm_latch p=%0d got latch=%b oe_n=%b want 1/1", p, bus.latch, bus.oe_n); end
      tick();
      while (bus.oe_n === 1'b0 && run < 200) begin
        tests++; if (bus.latch !== 1'b0 || bus.sclk !== 1'b0) begin fails++; $display("FAIL bcm_display_pins p=%0d got latch=%b sclk=%b want 0/0", p, bus.latch, bus.sclk); end
        run++;
        tick();
      end
      tests++; if (run != (8 << p)) begin fails++; $display("FAIL bcm_run p=%0d got=%0d want=%0d", p, run, 8 << p); end
      tests++; if (bus.oe_n !== 1'b1 || bus.latch !== 1'b0) begin fails++; $display("FAIL bcm_blank p=%0d got oe_n=%b latch=%b want 1/0", p, bus.oe_n, bus.latch); end
      tick();
      if (p < 3) begin
        tests++; if (bus.fb_plane !== 2'(p + 1) || bus.fb_row !== 4'd0 || bus.fb_rd !== 1'b1) begin fails++; $display("FAIL bcm_next_plane p=%0d got plane=%0d row=%0d rd=%b want %0d/0/1", p, bus.fb_plane, bus.fb_row, bus.fb_rd, p + 1); end
        repeat (129) tick();
      end else begin
        tests++; if (bus.fb_plane !== 2'd0 || bus.fb_row !== 4'd1 || bus.frame_start !== 1'b0) begin fails++; $display("FAIL bcm_next_row got plane=%0d row=%0d fs=%b want 0/1/0", bus.fb_plane, bus.fb_row, bus.frame_start); end
      end
    end
  endtask

  // Measures one complete frame. Leaves on the following frame_start cycle.
  task automatic test_frame_wrap();
    int n;
    int idx;
    int changes;
    logic [3:0] prev;
    n = 0;
    idx = 0;
    changes = 0;
    while (bus.frame_start !== 1'b1 && n < 12000) begin tick(); n++; end
    tests++; if (bus.frame_start !== 1'b1) begin fails++; $display("FAIL wrap_wait got fs=%b want=1 after %0d cycles", bus.frame_start, n); end
    prev = bus.addr;
    tests++; if (prev !== 4'd15) begin fails++; $display("FAIL wrap_addr_at_start got=%0d want=15", prev); end
    do begin
      tick();
      idx++;
      tests++;
      if ((bus.oe_n === 1'b0 && bus.latch !== 1'b0) || (bus.sclk === 1'b1 && (bus.latch !== 1'b0 || bus.oe_n !== 1'b1))) begin
        fails++; $display("FAIL wrap_pin_overlap cyc=%0d got oe_n=%b latch=%b sclk=%b", idx, bus.oe_n, bus.latch, bus.sclk);
      end
      if (bus.addr !== prev) begin
        tests++; if (bus.latch !== 1'b1 || bus.addr !== 4'(prev + 1)) begin fails++; $display("FAIL wrap_addr_step cyc=%0d got addr=%0d latch=%b want addr=%0d latch=1", idx, bus.addr, bus.latch, 4'(prev + 1)); end
        changes++;
        prev = bus.addr;
      end
    end while (bus.frame_start !== 1'b1 && idx < 12000);
    tests++; if (idx != 10304) begin fails++; $display("FAIL wrap_frame_period got=%0d want=10304", idx); end
    tests++; if (changes != 16) begin fails++; $display("FAIL wrap_addr_changes got=%0d want=16", changes); end
  endtask

  // Entered on a frame_start cycle. en is dropped at row 7.
  task automatic test_en_drop();
    int idx;
    int last_low;
    int fs_seen;
    bit dropped;
    idx = 0;
    last_low = -1;
    fs_seen = 0;
    dropped = 1'b0;
    while (idx < 10304 + 20) begin
      if (!dropped && bus.fb_row === 4'd7) begin
        en = 1'b0;
        dropped = 1'b1;
      end
      tick();
      idx++;
      if (bus.oe_n === 1'b0) last_low = idx;
      if (bus.frame_start === 1'b1) fs_seen++;
    end
    tests++; if (dropped !== 1'b1) begin fails++; $display("FAIL endrop_row7_reached got=%b want=1", dropped); end
    tests++; if (fs_seen != 0) begin fails++; $display("FAIL endrop_no_restart got=%0d pulses want=0", fs_seen); end
    tests++; if (last_low != 10302) begin fails++; $display("FAIL endrop_last_display got=%0d want=10302", last_low); end
    tests++; if (bus.oe_n !== 1'b1 || bus.fb_rd !== 1'b0 || bus.sclk !== 1'b0) begin fails++; $display("FAIL endrop_idle got oe_n=%b rd=%b sclk=%b want 1/0/0", bus.oe_n, bus.fb_rd, bus.sclk); end
    tests++; if (bus.addr !== 4'd15) begin fails++; $display("FAIL endrop_final_addr got=%0d want=15", bus.addr); end
    en = 1'b1;
    tick();
    tests++; if (bus.frame_start !== 1'b1 || bus.fb_row !== 4'd0) begin fails++; $display("FAIL endrop_restart got fs=%b row=%0d want 1/0", bus.frame_start, bus.fb_row); end
  endtask

  task automatic test_reset_midframe();
    int n;
    n = 0;
    while (!(bus.fb_row === 4'd2 && bus.oe_n === 1'b0) && n < 3000) begin tick(); n++; end
    tests++; if (bus.oe_n !== 1'b0 || bus.addr !== 4'd2) begin fails++; $display("FAIL rstmid_reach_display got oe_n=%b addr=%0d want 0/2", bus.oe_n, bus.addr); end
    rst = 1'b0;
    en  = 1'b0;
    tick();
    tests++; if (bus.oe_n !== 1'b1 || bus.sclk !== 1'b0 || bus.latch !== 1'b0) begin fails++; $display("FAIL rstmid_pins got oe_n=%b sclk=%b latch=%b want 1/0/0", bus.oe_n, bus.sclk, bus.latch); end
    tests++; if (bus.addr !== 4'd0 || bus.fb_row !== 4'd0 || bus.fb_rd !== 1'b0) begin fails++; $display("FAIL rstmid_state got addr=%0d row=%0d rd=%b want 0/0/0", bus.addr, bus.fb_row, bus.fb_rd); end
    rst = 1'b1;
    tick();
    tick();
    tests++; if (bus.oe_n !== 1'b1 || bus.fb_rd !== 1'b0 || bus.frame_start !== 1'b0) begin fails++; $display("FAIL rstmid_idle got oe_n=%b rd=%b fs=%b want 1/0/0", bus.oe_n, bus.fb_rd, bus.frame_start); end
    en = 1'b1;
    tick();
    tests++; if (bus.frame_start !== 1'b1 || bus.fb_plane !== 2'd0) begin fails++; $display("FAIL rstmid_restart got fs=%b plane=%0d want 1/0", bus.frame_start, bus.fb_plane); end
    en = 1'b0;
  endtask

  task automatic test_small_config();
    int n;
    int idx;
    int lows;
    int addr_chg;
    n = 0;
    idx = 0;
    lows = 0;
    addr_chg = -1;
    en2 = 1'b1;
    while (bus2.frame_start !== 1'b1 && n < 20) begin tick(); n++; end
    tests++; if (bus2.frame_start !== 1'b1) begin fails++; $display("FAIL small_start got fs=%b want=1", bus2.frame_start); end
    do begin
      tick();
      idx++;
      if (bus2.oe_n === 1'b0) lows++;
      if (addr_chg < 0 && bus2.addr === 1'b1) addr_chg = idx;
    end while (bus2.frame_start !== 1'b1 && idx < 200);
    tests++; if (idx != 50) begin fails++; $display("FAIL small_frame_period got=%0d want=50", idx); end
    tests++; if (addr_chg != 34) begin fails++; $display("FAIL small_row1_latch got=%0d want=34", addr_chg); end
    tests++; if (lows != 6) begin fails++; $display("FAIL small_oe_cycles got=%0d want=6", lows); end
    en2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_shift_timing();
    test_bcm_weights();
    test_frame_wrap();
    test_en_drop();
    test_reset_midframe();
    test_small_config();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
